// File: rtl/serial_mem_slave.sv
// Serial-bus slave with an internal word memory.
// A control frame (111 | ID | rdWr | burst | address) selects a single or burst
// transfer. Writes arrive bit-serially on wD (qualified by valid). Reads are
// returned on rD after RD_LATENCY cycles of ready low per word. Addresses wrap
// at ADDR_DEPTH, which need not be a power of two.
module serial_mem_slave #(
   parameter int ADDR_DEPTH = 4096,
   parameter int DATA_WIDTH = 8,
   parameter int SLAVES     = 3,
   parameter int SLAVEID    = 1,
   parameter int RD_LATENCY = 2
) (
   input  logic clk,
   input  logic rstN,
   input  logic control,
   input  logic wD,
   input  logic valid,
   input  logic last,
   output logic rD,
   output logic ready,
   output logic addrErr
);

   localparam int SID_W   = $clog2(SLAVES + 1);
   localparam int ADDR_W  = $clog2(ADDR_DEPTH);
   localparam int FRAME_W = SID_W + 2 + ADDR_W;
   localparam int FCNT_W  = $clog2(FRAME_W + 1);
   localparam int BCNT_W  = $clog2(DATA_WIDTH + 1);
   localparam int LCNT_W  = $clog2(RD_LATENCY + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CTRL,
      S_WRITE,
      S_RD_FETCH,
      S_RD_SHIFT
   } state_t;

   state_t              state_q, state_d;
   logic [1:0]          ones_q, ones_d;
   logic [FCNT_W-1:0]   fcnt_q, fcnt_d;
   logic [BCNT_W-1:0]   bcnt_q, bcnt_d;
   logic [LCNT_W-1:0]   lcnt_q, lcnt_d;
   logic                burst_q, burst_d;
   logic                lastSeen_q, lastSeen_d;
   logic                addrErr_q, addrErr_d;

   logic [FRAME_W-1:0]    frame_q;
   logic [ADDR_W-1:0]     addr_q;
   logic [DATA_WIDTH-1:0] wsh_q;
   logic [DATA_WIDTH-1:0] rsh_q;
   logic [DATA_WIDTH-1:0] mem [ADDR_DEPTH];

   // Strobes from the FSM to the datapath registers
   logic frame_shift, addr_load, addr_inc, wsh_shift, mem_we, rsh_load, rsh_shift;

   logic [SID_W-1:0]  frame_id;
   logic              frame_rdwr;
   logic              frame_burst;
   logic [ADDR_W-1:0] frame_addr;

   assign frame_id    = frame_q[FRAME_W-1 -: SID_W];
   assign frame_rdwr  = frame_q[ADDR_W+1];
   assign frame_burst = frame_q[ADDR_W];
   assign frame_addr  = frame_q[ADDR_W-1:0];

   // Wrapping address increment; the last valid word is followed by word 0.
   function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
      if (a == ADDR_W'(ADDR_DEPTH - 1)) return '0;
      return a + ADDR_W'(1);
   endfunction

   // Control state: FSM state, counters, flags and the error pulse
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         state_q    <= S_IDLE;
         ones_q     <= '0;
         fcnt_q     <= '0;
         bcnt_q     <= '0;
         lcnt_q     <= '0;
         burst_q    <= 1'b0;
         lastSeen_q <= 1'b0;
         addrErr_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         ones_q     <= ones_d;
         fcnt_q     <= fcnt_d;
         bcnt_q     <= bcnt_d;
         lcnt_q     <= lcnt_d;
         burst_q    <= burst_d;
         lastSeen_q <= lastSeen_d;
         addrErr_q  <= addrErr_d;
      end
   end

   // Next-state and datapath strobes
   always_comb begin
      state_d     = state_q;
      ones_d      = ones_q;
      fcnt_d      = fcnt_q;
      bcnt_d      = bcnt_q;
      lcnt_d      = lcnt_q;
      burst_d     = burst_q;
      lastSeen_d  = lastSeen_q;
      addrErr_d   = 1'b0;
      frame_shift = 1'b0;
      addr_load   = 1'b0;
      addr_inc    = 1'b0;
      wsh_shift   = 1'b0;
      mem_we      = 1'b0;
      rsh_load    = 1'b0;
      rsh_shift   = 1'b0;
      case (state_q)
         S_IDLE: begin
            // Look for three consecutive ones as the start pattern
            if (control) begin
               if (ones_q == 2'd2) begin
                  state_d = S_CTRL;
                  ones_d  = '0;
                  fcnt_d  = '0;
               end else begin
                  ones_d = ones_q + 2'd1;
               end
            end else begin
               ones_d = '0;
            end
         end
         S_CTRL: begin
            if (fcnt_q != FCNT_W'(FRAME_W)) begin
               frame_shift = 1'b1;
               fcnt_d      = fcnt_q + FCNT_W'(1);
            end else begin
               // Decision cycle: the whole frame is in frame_q
               fcnt_d     = '0;
               bcnt_d     = '0;
               lcnt_d     = '0;
               lastSeen_d = 1'b0;
               state_d    = S_IDLE;
               if (frame_id == SID_W'(SLAVEID)) begin
                  if ({1'b0, frame_addr} >= (ADDR_W + 1)'(ADDR_DEPTH)) begin
                     addrErr_d = 1'b1;
                  end else begin
                     addr_load = 1'b1;
                     burst_d   = frame_burst;
                     state_d   = frame_rdwr ? S_WRITE : S_RD_FETCH;
                  end
               end
            end
         end
         S_WRITE: begin
            if (valid) begin
               wsh_shift = 1'b1;
               if (bcnt_q == BCNT_W'(DATA_WIDTH - 1)) begin
                  mem_we = 1'b1;
                  bcnt_d = '0;
                  if (last || !burst_q) state_d = S_IDLE;
                  else                  addr_inc = 1'b1;
               end else if (last) begin
                  // Incomplete word at the end of the burst is dropped
                  bcnt_d  = '0;
                  state_d = S_IDLE;
               end else begin
                  bcnt_d = bcnt_q + BCNT_W'(1);
               end
            end
         end
         S_RD_FETCH: begin
            if (last) lastSeen_d = 1'b1;
            if (lcnt_q == LCNT_W'(RD_LATENCY - 1)) begin
               lcnt_d   = '0;
               rsh_load = 1'b1;
               state_d  = S_RD_SHIFT;
            end else begin
               lcnt_d = lcnt_q + LCNT_W'(1);
            end
         end
         S_RD_SHIFT: begin
            rsh_shift = 1'b1;
            if (bcnt_q == BCNT_W'(DATA_WIDTH - 1)) begin
               bcnt_d = '0;
               if (burst_q && !lastSeen_q && !last) begin
                  addr_inc = 1'b1;
                  state_d  = S_RD_FETCH;
               end else begin
                  lastSeen_d = 1'b0;
                  state_d    = S_IDLE;
               end
            end else begin
               bcnt_d = bcnt_q + BCNT_W'(1);
               if (last) lastSeen_d = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Datapath registers: frame shifter, address, write and read shifters
   always_ff @(posedge clk) begin
      if (frame_shift) frame_q <= {frame_q[FRAME_W-2:0], control};
      if (addr_load)     addr_q <= frame_addr;
      else if (addr_inc) addr_q <= next_addr(addr_q);
      if (wsh_shift) wsh_q <= {wsh_q[DATA_WIDTH-2:0], wD};
      if (rsh_load)       rsh_q <= mem[addr_q];
      else if (rsh_shift) rsh_q <= {rsh_q[DATA_WIDTH-2:0], 1'b0};
   end

   // Word memory; the final bit goes straight in alongside the shifted bits
   always_ff @(posedge clk) begin
      if (mem_we) mem[addr_q] <= {wsh_q[DATA_WIDTH-2:0], wD};
   end

   assign rD      = (state_q == S_RD_SHIFT) ? rsh_q[DATA_WIDTH-1] : 1'b0;
   assign ready   = (state_q != S_RD_FETCH);
   assign addrErr = addrErr_q;

endmodule

// File: tb/tb_serial_mem_slave.sv
// Bench for serial_mem_slave: two instances (depth 4096 and 3000) share the bus
// inputs; a word-level memory model per instance predicts every output cycle.
module tb_serial_mem_slave;

   localparam int W     = 8;
   localparam int L     = 2;
   localparam int SID_W = 2;
   localparam int AW    = 12;
   localparam int F     = SID_W + 2 + AW;
   localparam int P     = L + W;

   logic clk = 1'b0;
   logic rstN = 1'b0;
   logic control = 1'b0, wD = 1'b0, valid = 1'b0, last = 1'b0;
   logic rD_a, ready_a, addrErr_a;
   logic rD_b, ready_b, addrErr_b;

   int n_chk = 0;
   int n_pass = 0;
   int depth [2] = '{4096, 3000};
   int mdl [2][4096];
   bit exp_err [2];

   serial_mem_slave #(.ADDR_DEPTH(4096), .DATA_WIDTH(W), .SLAVES(3), .SLAVEID(1), .RD_LATENCY(L)) u_dut_a (
      .clk(clk), .rstN(rstN), .control(control), .wD(wD), .valid(valid), .last(last),
      .rD(rD_a), .ready(ready_a), .addrErr(addrErr_a));

   serial_mem_slave #(.ADDR_DEPTH(3000), .DATA_WIDTH(W), .SLAVES(3), .SLAVEID(1), .RD_LATENCY(L)) u_dut_b (
      .clk(clk), .rstN(rstN), .control(control), .wD(wD), .valid(valid), .last(last),
      .rD(rD_b), .ready(ready_b), .addrErr(addrErr_b));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   // Compare one instance's outputs; a negative expectation means "don't care"
   task automatic samp(input string ph, input int d, input int er, input int ed, input int ee);
      logic r, y, e;
      r = (d == 0) ? rD_a      : rD_b;
      y = (d == 0) ? ready_a   : ready_b;
      e = (d == 0) ? addrErr_a : addrErr_b;
      chk($sformatf("%s.dut%0d.ready", ph, d), {31'b0, y}, er);
      if (ed >= 0) chk($sformatf("%s.dut%0d.rD", ph, d), {31'b0, r}, ed);
      chk($sformatf("%s.dut%0d.addrErr", ph, d), {31'b0, e}, ee);
   endtask

   function automatic bit hit(input int d, input int id, input int addr);
      return (id == 1) && (addr < depth[d]);
   endfunction

   task automatic send_frame(input int id, input bit rdwr, input bit burst, input int addr);
      logic [F+2:0] fr;
      fr = {3'b111, SID_W'(id), rdwr, burst, AW'(addr)};
      for (int k = F + 2; k >= 0; k--) begin
         for (int d = 0; d < 2; d++) samp("frame", d, 1, 0, 0);
         control = fr[k];
         @(negedge clk);
      end
      for (int d = 0; d < 2; d++) samp("decide", d, 1, 0, 0);
      control = 1'b0;
      @(negedge clk);
      for (int d = 0; d < 2; d++) exp_err[d] = (id == 1) && (addr >= depth[d]);
   endtask

   task automatic idle(input int n);
      for (int c = 0; c < n; c++) begin
         for (int d = 0; d < 2; d++) samp("idle", d, 1, 0, (c == 0) ? int'(exp_err[d]) : 0);
         @(negedge clk);
      end
      exp_err = '{0, 0};
   endtask

   task automatic do_write(input int id, input int addr, input bit burst, input logic [7:0] words[$],
                           input int gapmax, input int fgap_after, input int fgap_len);
      int c;
      int sent;
      int g;
      int a;
      c = 0;
      sent = 0;
      send_frame(id, 1'b1, burst, addr);
      for (int i = 0; i < words.size(); i++) begin
         for (int b = W - 1; b >= 0; b--) begin
            g = (gapmax > 0) ? $urandom_range(0, gapmax) : 0;
            if (fgap_after > 0 && sent == fgap_after) g = g + fgap_len;
            for (int k = 0; k < g; k++) begin
               for (int d = 0; d < 2; d++) samp("wgap", d, 1, 0, (c == 0) ? int'(exp_err[d]) : 0);
               valid = 1'b0;
               wD    = 1'($urandom_range(0, 1));
               last  = 1'b0;
               @(negedge clk);
               c++;
            end
            for (int d = 0; d < 2; d++) samp("write", d, 1, 0, (c == 0) ? int'(exp_err[d]) : 0);
            valid = 1'b1;
            wD    = words[i][b];
            last  = burst && (i == words.size() - 1) && (b == 0);
            @(negedge clk);
            c++;
            sent++;
         end
      end
      valid = 1'b0;
      wD    = 1'b0;
      last  = 1'b0;
      exp_err = '{0, 0};
      for (int d = 0; d < 2; d++) begin
         if (hit(d, id, addr)) begin
            a = addr;
            for (int i = 0; i < words.size(); i++) begin
               mdl[d][a] = int'(words[i]);
               a = (a + 1) % depth[d];
            end
         end
      end
      idle(2);
   endtask

   task automatic do_read(input int id, input int addr, input bit burst, input int lastword,
                          input int lastoff, input int abort);
      int nw, tot, lc, er, ed, w, o, v;
      send_frame(id, 1'b0, burst, addr);
      nw  = burst ? lastword + 1 : 1;
      tot = nw * P + 2;
      lc  = lastword * P + lastoff;
      for (int c = 0; c < tot; c++) begin
         for (int d = 0; d < 2; d++) begin
            er = 1;
            ed = 0;
            if (hit(d, id, addr) && c < nw * P) begin
               w = c / P;
               o = c % P;
               if (o < L) begin
                  er = 0;
               end else begin
                  v  = mdl[d][(addr + w) % depth[d]];
                  ed = (v < 0) ? -1 : ((v >> (W - 1 - (o - L))) & 1);
               end
            end
            samp("read", d, er, ed, (c == 0) ? int'(exp_err[d]) : 0);
         end
         if (c == abort) begin
            rstN = 1'b0;
            #1;
            for (int d = 0; d < 2; d++) samp("reset", d, 1, 0, 0);
            last = 1'b0;
            @(negedge clk);
            @(negedge clk);
            rstN = 1'b1;
            exp_err = '{0, 0};
            return;
         end
         last = burst && (c == lc);
         @(negedge clk);
      end
      last = 1'b0;
      exp_err = '{0, 0};
   endtask

   initial begin
      #3000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [7:0] q[$];
      int edges [5] = '{0, 2998, 2999, 4094, 4095};
      int id, addr, n, lw, off;
      bit burst;

      for (int d = 0; d < 2; d++)
         for (int i = 0; i < 4096; i++) mdl[d][i] = -1;
      exp_err = '{0, 0};

      // Reset values while rstN is held low
      @(negedge clk);
      for (int d = 0; d < 2; d++) samp("rst", d, 1, 0, 0);
      @(negedge clk);
      rstN = 1'b1;

      // Single write / single read
      q = {}; q.push_back(8'hA5);
      do_write(1, 6, 1'b0, q, 0, 0, 0);
      do_read(1, 6, 1'b0, 0, 0, -1);

      // Burst write across the top of the 4096 array, then terminated burst read
      q = {}; q.push_back(8'h0E); q.push_back(8'h11); q.push_back(8'h12);
      do_write(1, 4094, 1'b1, q, 0, 0, 0);
      do_read(1, 4094, 1'b1, 2, L + 3, -1);

      // Frame for another slave is ignored
      q = {}; q.push_back(8'hFF);
      do_write(2, 6, 1'b0, q, 0, 0, 0);
      do_read(1, 6, 1'b0, 0, 0, -1);

      // Valid gap of three cycles after the fourth bit
      q = {}; q.push_back(8'h3C);
      do_write(1, 10, 1'b0, q, 0, 4, 3);
      do_read(1, 10, 1'b0, 0, 0, -1);

      // Out-of-range frame for the 3000-deep instance, then wrap at 2999
      q = {}; q.push_back(8'h77);
      do_write(1, 3500, 1'b0, q, 0, 0, 0);
      q = {}; q.push_back(8'hC3); q.push_back(8'h5A);
      do_write(1, 2999, 1'b1, q, 0, 0, 0);
      do_read(1, 2999, 1'b1, 1, P - 1, -1);
      do_read(1, 0, 1'b0, 0, 0, -1);

      // Reset during the fifth read bit and during a fetch, then normal reads
      do_read(1, 6, 1'b1, 2, 0, L + 4);
      do_read(1, 6, 1'b0, 0, 0, -1);
      do_read(1, 4094, 1'b1, 2, 0, 1);
      do_read(1, 6, 1'b0, 0, 0, -1);

      // Randomized transfers with random gaps, bursts and last placement
      for (int it = 0; it < 30; it++) begin
         id    = ($urandom_range(0, 7) == 0) ? 2 : 1;
         addr  = ($urandom_range(0, 2) == 0) ? edges[$urandom_range(0, 4)] : int'($urandom_range(0, 4095));
         burst = 1'($urandom_range(0, 1));
         n     = burst ? int'($urandom_range(1, 4)) : 1;
         q = {};
         for (int i = 0; i < n; i++) q.push_back(8'($urandom_range(0, 255)));
         do_write(id, addr, burst, q, 2, 0, 0);
         lw  = burst ? int'($urandom_range(0, n - 1)) : 0;
         off = $urandom_range(0, P - 1);
         do_read(1, addr, burst, lw, off, -1);
      end

      idle(2);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
